// File: rtl/conv_pkg.sv
// conv_pkg: shared types and helpers for the convolution stages.
//   convt_state_t    : transposed-conv FSM states
//   PIXEL_W          : pixel / accumulator width (signed)
//   convt_out_width  : output edge of a transposed conv, (iw-1)*stride + ks
package conv_pkg;
  localparam int PIXEL_W = 32;

  typedef enum logic [1:0] {IDLE, CLEAR, ACCUM, DONE} convt_state_t;

  function automatic int convt_out_width(int iw, int ks, int stride);
    return (iw - 1) * stride + ks;
  endfunction
endpackage

// File: rtl/conv_mac.sv
// conv_mac: combinational y = acc + a*b on signed operands.
//   a   : signed PIXEL_W pixel
//   b   : signed weight_width tap
//   acc : signed PIXEL_W running sum
//   y   : signed PIXEL_W result
// Build option CONV_TRANSPOSE_SATURATE_EN: clamp the product and the sum to
// the signed PIXEL_W range; otherwise both wrap modulo 2^PIXEL_W.
module conv_mac
  import conv_pkg::*;
#(
  parameter int weight_width = 8
) (
  input  logic signed [PIXEL_W-1:0]      a,
  input  logic signed [weight_width-1:0] b,
  input  logic signed [PIXEL_W-1:0]      acc,
  output logic signed [PIXEL_W-1:0]      y
);
`ifdef CONV_TRANSPOSE_SATURATE_EN
  localparam int PW = PIXEL_W + weight_width;
  localparam logic [PIXEL_W-1:0] SMAX = {1'b0, {(PIXEL_W-1){1'b1}}};
  localparam logic [PIXEL_W-1:0] SMIN = {1'b1, {(PIXEL_W-1){1'b0}}};

  logic signed [PW-1:0]      prod;
  logic signed [PIXEL_W-1:0] p_sat;
  logic signed [PIXEL_W:0]   sum;

  assign prod = PW'(a) * PW'(b);

  always_comb begin
    // product fits when every bit above the sign position agrees
    if ((&prod[PW-1:PIXEL_W-1]) || ~(|prod[PW-1:PIXEL_W-1]))
      p_sat = prod[PIXEL_W-1:0];
    else
      p_sat = prod[PW-1] ? SMIN : SMAX;
    sum = {p_sat[PIXEL_W-1], p_sat} + {acc[PIXEL_W-1], acc};
    if (sum[PIXEL_W] != sum[PIXEL_W-1])
      y = sum[PIXEL_W] ? SMIN : SMAX;
    else
      y = sum[PIXEL_W-1:0];
  end
`else
  // low PIXEL_W bits of the full product only depend on the sign-extended tap
  logic signed [PIXEL_W-1:0] b_ext;
  assign b_ext = PIXEL_W'(b);
  assign y     = a * b_ext + acc;
`endif
endmodule

// File: rtl/conv_transpose2d.sv
// conv_transpose2d: sequential transposed 2-D convolution, one MAC per cycle.
//   clk, reset   : clock, synchronous active-high reset
//   start        : request, accepted in IDLE or DONE
//   filter       : KS*KS signed taps, (ky,kx) at [(ky*KS+kx)*weight_width +: weight_width]
//   input_image  : IW*IW signed 32-bit pixels, (iy,ix) at [(iy*IW+ix)*32 +: 32]
//   output_image : OW*OW signed 32-bit results, registered
//   busy         : high in CLEAR and ACCUM
//   done         : high in DONE, output_image valid
// Build option CONV_TRANSPOSE_SATURATE_EN selects saturating arithmetic in conv_mac.
module conv_transpose2d
  import conv_pkg::*;
#(
  parameter int kernel_size  = 3,
  parameter int weight_width = 8,
  parameter int stride       = 2,
  parameter int input_width  = 4
) (
  input  logic                                             clk,
  input  logic                                             reset,
  input  logic                                             start,
  input  logic [kernel_size*kernel_size*weight_width-1:0]  filter,
  input  logic [input_width*input_width*PIXEL_W-1:0]       input_image,
  output logic [convt_out_width(input_width, kernel_size, stride)**2*PIXEL_W-1:0] output_image,
  output logic                                             busy,
  output logic                                             done
);
  localparam int OW  = convt_out_width(input_width, kernel_size, stride);
  localparam int NI  = input_width * input_width;
  localparam int NK  = kernel_size * kernel_size;
  localparam int NO  = OW * OW;
  localparam int CIW = (input_width > 1) ? $clog2(input_width) : 1;
  localparam int CKW = (kernel_size > 1) ? $clog2(kernel_size) : 1;
  localparam int IIW = (NI > 1) ? $clog2(NI) : 1;
  localparam int KIW = (NK > 1) ? $clog2(NK) : 1;
  localparam int OIW = (NO > 1) ? $clog2(NO) : 1;

  convt_state_t state, state_nxt;

  logic [CIW-1:0] iy, ix;
  logic [CKW-1:0] ky, kx;
  logic           last_iy, last_ix, last_ky, last_kx, last_mac;

  logic [NO-1:0][PIXEL_W-1:0]      out_r;
  logic [NI-1:0][PIXEL_W-1:0]      pix;
  logic [NK-1:0][weight_width-1:0] taps;

  logic [IIW-1:0] i_idx;
  logic [KIW-1:0] k_idx;
  logic [OIW-1:0] o_idx;
  logic [PIXEL_W-1:0] mac_y;

  assign pix          = input_image;
  assign taps         = filter;
  assign output_image = out_r;

  assign last_iy  = (iy == CIW'(input_width - 1));
  assign last_ix  = (ix == CIW'(input_width - 1));
  assign last_ky  = (ky == CKW'(kernel_size - 1));
  assign last_kx  = (kx == CKW'(kernel_size - 1));
  assign last_mac = last_iy & last_ix & last_ky & last_kx;

  // scatter target: out[stride*iy+ky][stride*ix+kx], always in range
  assign i_idx = IIW'(int'(iy) * input_width + int'(ix));
  assign k_idx = KIW'(int'(ky) * kernel_size + int'(kx));
  assign o_idx = OIW'((stride * int'(iy) + int'(ky)) * OW + stride * int'(ix) + int'(kx));

  conv_mac #(.weight_width(weight_width)) u_mac (
    .a   (pix[i_idx]),
    .b   (taps[k_idx]),
    .acc (out_r[o_idx]),
    .y   (mac_y)
  );

  // state register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // next state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (start) state_nxt = CLEAR;
      CLEAR:      state_nxt = ACCUM;
      ACCUM:      if (last_mac) state_nxt = DONE;
      default:    state_nxt = IDLE;
    endcase
  end

  // outputs
  always_comb begin
    busy = (state == CLEAR) || (state == ACCUM);
    done = (state == DONE);
  end

  // datapath: result array and iy/ix/ky/kx loop counters (kx innermost)
  always_ff @(posedge clk) begin
    if (reset || state == CLEAR) begin
      out_r <= '0;
      iy    <= '0;
      ix    <= '0;
      ky    <= '0;
      kx    <= '0;
    end else if (state == ACCUM) begin
      out_r[o_idx] <= mac_y;
      if (!last_kx) kx <= kx + 1'b1;
      else begin
        kx <= '0;
        if (!last_ky) ky <= ky + 1'b1;
        else begin
          ky <= '0;
          if (!last_ix) ix <= ix + 1'b1;
          else begin
            ix <= '0;
            iy <= last_iy ? '0 : iy + 1'b1;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_conv_transpose2d.sv
// tb_conv_transpose2d: randomized check of conv_transpose2d against a
// scatter-accumulate reference model, plus directed cases on a 2x2 instance.
module tb_conv_transpose2d;
  localparam int KS = 3, WW = 8, S = 2, IW = 4, OW = 9;
  localparam int NA = (IW*IW*KS*KS) + 2;  // done latency, default instance
  localparam int NB = (2*2*2*2) + 2;      // done latency, small instance

  logic clk = 1'b0;
  logic reset, start_a, start_b;
  logic [KS*KS*WW-1:0] filt_a;
  logic [IW*IW*32-1:0] img_a;
  logic [OW*OW*32-1:0] out_a;
  logic busy_a, done_a;
  logic [2*2*WW-1:0] filt_b;
  logic [2*2*32-1:0] img_b;
  logic [4*4*32-1:0] out_b;
  logic busy_b, done_b;

  int errors = 0, checks = 0;
  int tin[IW*IW];
  int tw[KS*KS];
  int expv[OW*OW];

  always #5 clk = ~clk;

  conv_transpose2d #(.kernel_size(KS), .weight_width(WW), .stride(S), .input_width(IW)) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .filter(filt_a), .input_image(img_a),
    .output_image(out_a), .busy(busy_a), .done(done_a));

  conv_transpose2d #(.kernel_size(2), .weight_width(WW), .stride(2), .input_width(2)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .filter(filt_b), .input_image(img_b),
    .output_image(out_b), .busy(busy_b), .done(done_b));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

`ifdef CONV_TRANSPOSE_SATURATE_EN
  function automatic longint clamp(longint v);
    if (v > 64'sd2147483647) return 64'sd2147483647;
    if (v < -64'sd2147483648) return -64'sd2147483648;
    return v;
  endfunction
`endif

  // every input pixel times every tap lands on out[S*iy+ky][S*ix+kx]
  function automatic void model();
    longint acc[OW*OW];
    longint p;
    int o;
    foreach (acc[i]) acc[i] = 0;
    for (int iy = 0; iy < IW; iy++)
      for (int ix = 0; ix < IW; ix++)
        for (int ky = 0; ky < KS; ky++)
          for (int kx = 0; kx < KS; kx++) begin
            o = (S*iy + ky) * OW + S*ix + kx;
            p = longint'(tin[iy*IW + ix]) * longint'(tw[ky*KS + kx]);
`ifdef CONV_TRANSPOSE_SATURATE_EN
            acc[o] = clamp(acc[o] + clamp(p));
`else
            acc[o] = longint'(int'(acc[o] + p));
`endif
          end
    foreach (acc[i]) expv[i] = int'(acc[i]);
  endfunction

  task automatic load_a();
    for (int i = 0; i < IW*IW; i++) img_a[i*32 +: 32] = tin[i];
    for (int i = 0; i < KS*KS; i++) filt_a[i*WW +: WW] = tw[i][WW-1:0];
  endtask

  task automatic check_out_a(input string tag);
    for (int i = 0; i < OW*OW; i++)
      chk($sformatf("%s_out%0d", tag, i), out_a[i*32 +: 32], expv[i]);
  endtask

  // start pulse sampled on edge 1; optional extra start pulse during ACCUM
  task automatic run_a(input int pulse_at, output int cyc, output logic d1, output logic b1);
    @(negedge clk);
    start_a = 1'b1;
    cyc = 0; d1 = 1'b1; b1 = 1'b0;
    while (cyc < 400) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == 1) begin start_a = 1'b0; d1 = done_a; b1 = busy_a; end
      if (cyc == pulse_at) start_a = 1'b1;
      if (cyc == pulse_at + 1) start_a = 1'b0;
      if (done_a) break;
    end
  endtask

  initial begin
    int cyc;
    logic d1, b1;
    int e1[16] = '{1,1,2,2, 1,1,2,2, 3,3,4,4, 3,3,4,4};
    reset = 1'b1; start_a = 1'b0; start_b = 1'b0;
    filt_a = '0; img_a = '0; filt_b = '0; img_b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_a", {31'd0, |out_a}, 32'd0);
    chk("rst_busy_a", {31'd0, busy_a}, 32'd0);
    chk("rst_done_a", {31'd0, done_a}, 32'd0);
    chk("rst_out_b", {31'd0, |out_b}, 32'd0);
    @(negedge clk) reset = 1'b0;

    // small instance: in=[1,2;3,4], taps 1, stride 2 -> non-overlapping blocks
    for (int i = 0; i < 4; i++) begin
      img_b[i*32 +: 32] = i + 1;
      filt_b[i*WW +: WW] = 8'd1;
    end
    @(negedge clk) start_b = 1'b1;
    cyc = 0;
    while (cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == 1) start_b = 1'b0;
      if (done_b) break;
    end
    chk("b_latency", cyc, NB);
    for (int i = 0; i < 16; i++) chk($sformatf("b_out%0d", i), out_b[i*32 +: 32], e1[i]);

    // overflow: four max pixels accumulate at (2,2)
    foreach (tin[i]) tin[i] = 32'h7FFFFFFF;
    foreach (tw[i]) tw[i] = 1;
    load_a(); model();
    run_a(-10, cyc, d1, b1);
    chk("ovf_latency", cyc, NA);
    check_out_a("ovf");
`ifdef CONV_TRANSPOSE_SATURATE_EN
    chk("ovf_centre", out_a[(2*OW+2)*32 +: 32], 32'h7FFFFFFF);
`else
    chk("ovf_centre", out_a[(2*OW+2)*32 +: 32], 32'hFFFFFFFC);
`endif

    // randomized passes, each restarted from DONE; round 0 pulses start mid-ACCUM
    for (int r = 0; r < 4; r++) begin
      foreach (tin[i]) tin[i] = (r == 3) ? int'($urandom_range(0, 200)) - 100 : int'($urandom);
      foreach (tw[i]) tw[i] = (r == 3) ? -1 : int'($urandom_range(0, 255)) - 128;
      load_a(); model();
      run_a((r == 0) ? 6 : -10, cyc, d1, b1);
      chk($sformatf("r%0d_done_drop", r), {31'd0, d1}, 32'd0);
      chk($sformatf("r%0d_busy", r), {31'd0, b1}, 32'd1);
      chk($sformatf("r%0d_latency", r), cyc, NA);
      check_out_a($sformatf("r%0d", r));
    end

    // reset on the 5th ACCUM cycle (edges 1:CLEAR, 2..: ACCUM)
    foreach (tin[i]) tin[i] = int'($urandom_range(1, 1000));
    foreach (tw[i]) tw[i] = int'($urandom_range(1, 100));
    load_a(); model();
    @(negedge clk) start_a = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      @(posedge clk); #1;
      if (c == 1) start_a = 1'b0;
    end
    reset = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_out", {31'd0, |out_a}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy_a}, 32'd0);
    chk("mid_rst_done", {31'd0, done_a}, 32'd0);
    reset = 1'b0;
    run_a(-10, cyc, d1, b1);
    chk("post_rst_latency", cyc, NA);
    check_out_a("post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
